// File: rtl/wvb_readout_arbiter.sv
// wvb_readout_arbiter: round-robin drain of per-channel waveform buffers.
// Optional per-waveform trailer word: define WVB_RDR_TRAILER_EN.
module wvb_readout_arbiter #(
  parameter int P_N_CHAN     = 4,
  parameter int P_CHAN_WIDTH = 2,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_ADR_WIDTH  = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [P_N_CHAN-1:0]              chan_en,
  input  logic [P_N_CHAN-1:0]              hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_N_CHAN-1:0]              hdr_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]           out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_is_hdr,
  output logic                             out_last,
  output logic [P_CHAN_WIDTH-1:0]          out_chan,
  output logic                             busy,
  output logic [31:0]                      wvf_count
);

  localparam int AW = P_ADR_WIDTH;
  localparam int NW = P_ADR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_DATA,
`ifdef WVB_RDR_TRAILER_EN
    S_TRLR,
`endif
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [P_CHAN_WIDTH-1:0] ch_q, ch_d;
  logic [P_CHAN_WIDTH-1:0] ptr_q, ptr_d;
  logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [NW-1:0]           nsamp_q, nsamp_d;
  logic [NW-1:0]           idx_q, idx_d;
  logic [P_DATA_WIDTH-1:0] samp_q, samp_d;
  logic [31:0]             cnt_q, cnt_d;

  logic [P_N_CHAN-1:0]     cand;
  logic [P_N_CHAN-1:0]     ch_oh;
  logic                    pick_ok;
  logic [P_CHAN_WIDTH-1:0] pick_ch;
  logic [P_HDR_WIDTH-1:0]  pick_hdr;
  logic [AW-1:0]           pick_start;
  logic [AW-1:0]           pick_stop;
  logic [P_DATA_WIDTH-1:0] wvb_sel;
  logic                    last_samp;

  assign cand       = chan_en & ~hdr_empty;
  assign ch_oh      = P_N_CHAN'(1) << ch_q;
  assign pick_hdr   = hdr_data[pick_ch*P_HDR_WIDTH +: P_HDR_WIDTH];
  assign pick_start = pick_hdr[2*AW-1:AW];
  assign pick_stop  = pick_hdr[AW-1:0];
  assign wvb_sel    = wvb_data[ch_q*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign last_samp  = (idx_q == nsamp_q - NW'(1));
  assign out_chan   = ch_q;
  assign busy       = (state_q != S_IDLE);
  assign wvf_count  = cnt_q;

  // first candidate after the last grant, searching upward cyclically
  always_comb begin
    pick_ok = 1'b0;
    pick_ch = '0;
    for (int k = P_N_CHAN; k >= 1; k--) begin
      if (cand[(int'(ptr_q) + k) % P_N_CHAN]) begin
        pick_ok = 1'b1;
        pick_ch = P_CHAN_WIDTH'((int'(ptr_q) + k) % P_N_CHAN);
      end
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    hdr_d   = hdr_q;
    nsamp_d = nsamp_q;
    idx_d   = idx_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          ch_d    = pick_ch;
          hdr_d   = pick_hdr;
          nsamp_d = {1'b0, pick_stop - pick_start} + NW'(1);
          idx_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (out_ready) state_d = S_RD;
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        samp_d  = wvb_sel;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (out_ready) begin
          if (last_samp) begin
`ifdef WVB_RDR_TRAILER_EN
            state_d = S_TRLR;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + NW'(1);
            state_d = S_RD;
          end
        end
      end
`ifdef WVB_RDR_TRAILER_EN
      S_TRLR: begin
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        cnt_d   = cnt_q + 32'd1;
        ptr_d   = ch_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output word and strobes decoded from the current state
  always_comb begin
    out_valid  = 1'b0;
    out_is_hdr = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    hdr_rdreq  = '0;
    wvb_rdreq  = '0;
    wvb_rddone = '0;
    unique case (state_q)
      S_HDR: begin
        out_valid  = 1'b1;
        out_is_hdr = 1'b1;
        out_data   = hdr_q;
      end
      S_RD: begin
        wvb_rdreq = ch_oh;
        if (idx_q == '0) hdr_rdreq = ch_oh;
      end
      S_DATA: begin
        out_valid = 1'b1;
        out_data  = P_HDR_WIDTH'(samp_q);
`ifndef WVB_RDR_TRAILER_EN
        out_last  = last_samp;
`endif
      end
`ifdef WVB_RDR_TRAILER_EN
      S_TRLR: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = P_HDR_WIDTH'({16'hA5A5, 8'(ch_q), 16'(nsamp_q)});
      end
`endif
      S_DONE: wvb_rddone = ch_oh;
      default: ;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      ptr_q   <= P_CHAN_WIDTH'(P_N_CHAN - 1);
      hdr_q   <= '0;
      nsamp_q <= '0;
      idx_q   <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      hdr_q   <= hdr_d;
      nsamp_q <= nsamp_d;
      idx_q   <= idx_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// tb_wvb_readout_arbiter: randomized bench with buffer emulation
// and a round-robin stream model for wvb_readout_arbiter.
module tb_wvb_readout_arbiter;

  localparam int NC = 4;
  localparam int CW = 2;
  localparam int DW = 22;
  localparam int HW = 80;
  localparam int HD = 16;
  localparam int SD = 256;
`ifdef WVB_RDR_TRAILER_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NC-1:0]  chan_en = '0;
  logic [NC-1:0]  hdr_empty;
  logic [NC*HW-1:0] hdr_data;
  logic [NC*DW-1:0] wvb_data;
  logic [NC-1:0]  hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [HW-1:0]  out_data;
  logic           out_valid, out_is_hdr, out_last, busy;
  logic           out_ready = 1'b0;
  logic [CW-1:0]  out_chan;
  logic [31:0]    wvf_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wvb_readout_arbiter dut (
    .clk(clk), .rst_n(rst_n), .chan_en(chan_en),
    .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .wvb_data(wvb_data), .hdr_rdreq(hdr_rdreq),
    .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_is_hdr(out_is_hdr),
    .out_last(out_last), .out_chan(out_chan),
    .busy(busy), .wvf_count(wvf_count)
  );

  // waveform buffer emulation
  logic [HW-1:0] hmem [NC][HD];
  logic [DW-1:0] smem [NC][SD];
  int hwr [NC];
  int swr [NC];
  int hrd [NC];
  int srd [NC];
  int wf_base [NC][HD];
  int wf_n [NC][HD];

  always_comb begin
    hdr_empty = '0;
    hdr_data = '0;
    for (int i = 0; i < NC; i++) begin
      hdr_empty[i] = (hrd[i] == hwr[i]);
      hdr_data[i*HW +: HW] = hmem[i][hrd[i] % HD];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        hrd[i] <= 0;
        srd[i] <= 0;
      end
      wvb_data <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (hdr_rdreq[i]) hrd[i] <= hrd[i] + 1;
        if (wvb_rdreq[i]) begin
          wvb_data[i*DW +: DW] <= smem[i][srd[i] % SD];
          srd[i] <= srd[i] + 1;
        end
      end
    end
  end

  // transfer recorder and strobe monitor
  logic [HW-1:0] rec_data [$];
  logic          rec_hdr [$];
  logic          rec_last [$];
  logic [CW-1:0] rec_chan [$];
  int n_hpop [NC];
  int n_rd [NC];
  int n_done [NC];
  int viol = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rec_data.push_back(out_data);
      rec_hdr.push_back(out_is_hdr);
      rec_last.push_back(out_last);
      rec_chan.push_back(out_chan);
    end
    for (int i = 0; i < NC; i++) begin
      if (hdr_rdreq[i]) n_hpop[i]++;
      if (wvb_rdreq[i]) n_rd[i]++;
      if (wvb_rddone[i]) n_done[i]++;
    end
    if ($countones(hdr_rdreq) > 1 || $countones(wvb_rdreq) > 1 ||
        $countones(wvb_rddone) > 1)
      viol++;
    if (!busy && (|hdr_rdreq || |wvb_rdreq || |wvb_rddone))
      viol++;
  end

  task automatic clear_rec();
    rec_data.delete();
    rec_hdr.delete();
    rec_last.delete();
    rec_chan.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chan_en = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      hwr[i] = 0;
      swr[i] = 0;
    end
    clear_rec();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add_wf(input int ch, input int start, input int stop);
    int n;
    n = ((stop - start) % 4096 + 4096) % 4096 + 1;
    hmem[ch][hwr[ch]] = {24'($urandom), 32'($urandom),
                         12'(start), 12'(stop)};
    wf_base[ch][hwr[ch]] = swr[ch];
    wf_n[ch][hwr[ch]] = n;
    for (int j = 0; j < n; j++) begin
      smem[ch][swr[ch] % SD] = 22'($urandom);
      swr[ch]++;
    end
    hwr[ch]++;
  endtask

  task automatic wait_wf(input int n, input int budget);
    for (int c = 0; c < budget && int'(wvf_count) < n; c++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_data(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && !out_is_hdr) ok = 1'b1;
    end
  endtask

  // expected stream from the round-robin rule
  logic [HW-1:0] exp_data [$];
  logic          exp_hdr [$];
  logic          exp_last [$];
  logic [CW-1:0] exp_chan [$];
  int exp_wf;

  task automatic build_exp(input logic [NC-1:0] en);
    int rem [NC];
    int nxt [NC];
    int ptr, c, n, b;
    bit found;
    exp_data.delete();
    exp_hdr.delete();
    exp_last.delete();
    exp_chan.delete();
    exp_wf = 0;
    ptr = NC - 1;
    for (int i = 0; i < NC; i++) begin
      rem[i] = hwr[i];
      nxt[i] = 0;
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= NC; k++) begin
        c = (ptr + k) % NC;
        if (!found && en[c] && rem[c] > 0) begin
          found = 1'b1;
          n = wf_n[c][nxt[c]];
          b = wf_base[c][nxt[c]];
          exp_data.push_back(hmem[c][nxt[c]]);
          exp_hdr.push_back(1'b1);
          exp_last.push_back(1'b0);
          exp_chan.push_back(CW'(c));
          for (int j = 0; j < n; j++) begin
            exp_data.push_back(HW'(smem[c][(b + j) % SD]));
            exp_hdr.push_back(1'b0);
            exp_last.push_back(T == 0 && j == n - 1);
            exp_chan.push_back(CW'(c));
          end
          if (T == 1) begin
            exp_data.push_back(HW'({16'hA5A5, 8'(c), 16'(n)}));
            exp_hdr.push_back(1'b0);
            exp_last.push_back(1'b1);
            exp_chan.push_back(CW'(c));
          end
          rem[c]--;
          nxt[c]++;
          exp_wf++;
          ptr = c;
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl valid=%b busy=%b want 0 0", out_valid, busy);
    end
    total++;
    if (wvf_count !== 32'd0 || out_data !== '0 || out_chan !== '0) begin
      bad++;
      $display("FAIL reset_data cnt=%0d data=%h chan=%0d want 0",
               wvf_count, out_data, out_chan);
    end
    total++;
    if ((hdr_rdreq | wvb_rdreq | wvb_rddone) !== '0) begin
      bad++;
      $display("FAIL reset_strobes got %b want 0",
               hdr_rdreq | wvb_rdreq | wvb_rddone);
    end
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single();
    int d0, r0, h0;
    do_reset();
    d0 = n_done[1];
    r0 = n_rd[1];
    h0 = n_hpop[1];
    add_wf(1, 'h010, 'h013);
    chan_en = '1;
    out_ready = 1'b1;
    wait_wf(1, 200);
    total++;
    if (wvf_count !== 32'd1) begin
      bad++;
      $display("FAIL single_count got %0d want 1", wvf_count);
    end
    total++;
    if (rec_data.size() != 5 + T) begin
      bad++;
      $display("FAIL single_words got %0d want %0d", rec_data.size(), 5 + T);
    end else begin
      total++;
      if (rec_hdr[0] !== 1'b1 || rec_data[0] !== hmem[1][0]) begin
        bad++;
        $display("FAIL single_hdr got %h/%b want %h/1",
                 rec_data[0], rec_hdr[0], hmem[1][0]);
      end
      for (int j = 0; j < 4; j++) begin
        total++;
        if (rec_data[1+j] !== HW'(smem[1][j]) || rec_hdr[1+j] !== 1'b0 ||
            rec_last[1+j] !== (T == 0 && j == 3) || rec_chan[1+j] !== 2'd1) begin
          bad++;
          $display("FAIL single_samp%0d got %h last=%b want %h last=%b",
                   j, rec_data[1+j], rec_last[1+j], smem[1][j],
                   (T == 0 && j == 3));
        end
      end
      if (T == 1) begin
        total++;
        if (rec_data[5] !== HW'(40'hA5A5_01_0004) || rec_last[5] !== 1'b1) begin
          bad++;
          $display("FAIL single_trlr got %h last=%b want a5a5010004 1",
                   rec_data[5], rec_last[5]);
        end
      end
    end
    total++;
    if (n_done[1] - d0 != 1 || n_rd[1] - r0 != 4 || n_hpop[1] - h0 != 1) begin
      bad++;
      $display("FAIL single_strobes done=%0d rd=%0d pop=%0d want 1 4 1",
               n_done[1] - d0, n_rd[1] - r0, n_hpop[1] - h0);
    end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] hch [$];
    int want [4] = '{0, 2, 0, 2};
    do_reset();
    add_wf(0, 0, $urandom_range(0, 3));
    add_wf(0, 0, $urandom_range(0, 3));
    add_wf(2, 0, $urandom_range(0, 3));
    add_wf(2, 0, $urandom_range(0, 3));
    chan_en = '1;
    out_ready = 1'b1;
    wait_wf(4, 400);
    for (int i = 0; i < rec_data.size(); i++)
      if (rec_hdr[i]) hch.push_back(rec_chan[i]);
    total++;
    if (hch.size() != 4) begin
      bad++;
      $display("FAIL rr_grants got %0d want 4", hch.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (int'(hch[i]) != want[i]) begin
          bad++;
          $display("FAIL rr_order%0d got ch%0d want ch%0d", i, hch[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int seg [$];
    int cur;
    bit last_ok;
    do_reset();
    add_wf(0, 'hFFE, 'h001);
    add_wf(0, 'h005, 'h005);
    chan_en = '1;
    out_ready = 1'b1;
    wait_wf(2, 300);
    cur = -1;
    last_ok = 1'b1;
    for (int i = 0; i < rec_data.size(); i++) begin
      if (rec_hdr[i]) begin
        if (cur >= 0) seg.push_back(cur);
        cur = 0;
      end else begin
        cur++;
        if (rec_last[i] !== (i == rec_data.size() - 1 || rec_hdr[i+1]))
          last_ok = 1'b0;
      end
    end
    if (cur >= 0) seg.push_back(cur);
    total++;
    if (seg.size() != 2) begin
      bad++;
      $display("FAIL wrap_wfs got %0d want 2", seg.size());
    end else begin
      total++;
      if (seg[0] != 4 + T || seg[1] != 1 + T) begin
        bad++;
        $display("FAIL wrap_len got %0d,%0d want %0d,%0d",
                 seg[0], seg[1], 4 + T, 1 + T);
      end
    end
    total++;
    if (!last_ok) begin
      bad++;
      $display("FAIL wrap_last got misplaced out_last want final word only");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [HW-1:0] d0;
    logic l0;
    int r0;
    do_reset();
    add_wf(2, 0, 7);
    chan_en = '1;
    out_ready = 1'b1;
    wait_data(100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_reach got timeout want DATA");
    end
    out_ready = 1'b0;
    d0 = out_data;
    l0 = out_last;
    r0 = n_rd[2];
    repeat (5) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0 ||
          out_is_hdr !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold got %h v=%b want %h v=1", out_data, out_valid, d0);
      end
    end
    total++;
    if (n_rd[2] != r0) begin
      bad++;
      $display("FAIL bp_rdreq got %0d extra want 0", n_rd[2] - r0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (wvb_rdreq !== 4'b0100) begin
      bad++;
      $display("FAIL bp_resume got %b want 0100", wvb_rdreq);
    end
    wait_wf(1, 200);
    total++;
    if (wvf_count !== 32'd1 || rec_data.size() != 9 + T) begin
      bad++;
      $display("FAIL bp_done got cnt=%0d words=%0d want 1 %0d",
               wvf_count, rec_data.size(), 9 + T);
    end
  endtask

  task automatic test_chan_en_drop();
    bit ok;
    int d0, h0;
    do_reset();
    add_wf(1, 0, 5);
    add_wf(1, 0, 5);
    d0 = n_done[1];
    h0 = n_hpop[1];
    chan_en = '1;
    out_ready = 1'b1;
    wait_data(100, ok);
    chan_en[1] = 1'b0;
    wait_wf(1, 200);
    total++;
    if (!ok || wvf_count !== 32'd1 || n_done[1] - d0 != 1) begin
      bad++;
      $display("FAIL drop_finish got ok=%b cnt=%0d done=%0d want 1 1 1",
               ok, wvf_count, n_done[1] - d0);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || hdr_empty[1] !== 1'b0 || n_hpop[1] - h0 != 1 ||
        wvf_count !== 32'd1) begin
      bad++;
      $display("FAIL drop_regrant got busy=%b empty=%b pops=%0d want 0 0 1",
               busy, hdr_empty[1], n_hpop[1] - h0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    do_reset();
    add_wf(3, 0, 9);
    d0 = n_done[3];
    chan_en = '1;
    out_ready = 1'b1;
    wait_data(100, ok);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NC; i++) begin
      hwr[i] = 0;
      swr[i] = 0;
    end
    #1;
    total++;
    if (!ok || out_valid !== 1'b0 || busy !== 1'b0 ||
        (hdr_rdreq | wvb_rdreq | wvb_rddone) !== '0) begin
      bad++;
      $display("FAIL rstmid_async got ok=%b v=%b busy=%b want 1 0 0",
               ok, out_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || n_done[3] != d0 || wvf_count !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_idle got busy=%b done=%0d cnt=%0d want 0 0 0",
               busy, n_done[3] - d0, wvf_count);
    end
  endtask

  task automatic test_random();
    int len;
    int st;
    logic [NC-1:0] en;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      en = NC'($urandom_range(1, 15));
      for (int c = 0; c < NC; c++) begin
        for (int w = $urandom_range(0, 3); w > 0; w--) begin
          len = $urandom_range(1, 6);
          st = $urandom_range(0, 4095);
          add_wf(c, st, (st + len - 1) % 4096);
        end
      end
      build_exp(en);
      chan_en = en;
      for (int c = 0; c < 4000 && int'(wvf_count) < exp_wf; c++) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (int'(wvf_count) != exp_wf) begin
        bad++;
        $display("FAIL rand%0d_count got %0d want %0d", it, wvf_count, exp_wf);
      end
      total++;
      if (rec_data.size() != exp_data.size()) begin
        bad++;
        $display("FAIL rand%0d_words got %0d want %0d",
                 it, rec_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < rec_data.size(); i++) begin
        total++;
        if (rec_data[i] !== exp_data[i] || rec_hdr[i] !== exp_hdr[i] ||
            rec_last[i] !== exp_last[i] || rec_chan[i] !== exp_chan[i]) begin
          bad++;
          $display("FAIL rand%0d_w%0d got %h h%b l%b c%0d want %h h%b l%b c%0d",
                   it, i, rec_data[i], rec_hdr[i], rec_last[i], rec_chan[i],
                   exp_data[i], exp_hdr[i], exp_last[i], exp_chan[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_chan_en_drop();
    test_reset_mid();
    test_random();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL strobe_rules got %0d violations want 0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wvb_readout_arbiter.md
Name: wvb_readout_arbiter

Overview:
- Round-robin readout controller that drains up to P_N_CHAN waveform buffers (one per acquisition channel) into one output stream.
- Per waveform: pops the header, reads every sample, pulses rddone, then moves to the next channel.
- Sits between the per-channel waveform_acquisition instances and the downstream packetizer/host readout path.
- Owns all hdr_rdreq, wvb_rdreq and wvb_rddone strobes.

Parameters:
- P_N_CHAN, 4, number of waveform buffers served.
- P_CHAN_WIDTH, 2, width of channel index (>= clog2(P_N_CHAN)).
- P_DATA_WIDTH, 22, waveform sample word width.
- P_HDR_WIDTH, 80, header word width; also the out_data width.
- P_ADR_WIDTH, 12, waveform buffer address width.

Ports:
- clk  input  1  acquisition clock; one clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- chan_en  input  P_N_CHAN  per-channel readout enable.
- hdr_empty  input  P_N_CHAN  per-channel header FIFO empty.
- hdr_data  input  P_N_CHAN*P_HDR_WIDTH  packed headers, channel i at [i*P_HDR_WIDTH +: P_HDR_WIDTH], first-word-fall-through.
- wvb_data  input  P_N_CHAN*P_DATA_WIDTH  packed sample words, valid 1 cycle after wvb_rdreq.
- hdr_rdreq  output  P_N_CHAN  header pop strobe.
- wvb_rdreq  output  P_N_CHAN  sample read strobe.
- wvb_rddone  output  P_N_CHAN  waveform-complete strobe.
- out_data  output  P_HDR_WIDTH  header, or sample zero-extended.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_is_hdr  output  1  current word is a header.
- out_last  output  1  final word of this waveform.
- out_chan  output  P_CHAN_WIDTH  source channel of current word.
- busy  output  1  high in every state except IDLE.
- wvf_count  output  32  waveforms completed; wraps at 2^32.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n is low, all outputs are 0, the state is IDLE and the round-robin pointer is P_N_CHAN-1, so ch0 has first priority.
- Transfer rule: a word transfers on any cycle with out_valid && out_ready. out_data, out_is_hdr, out_last and out_chan are held stable while out_valid && !out_ready.
- Length decode: start = hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH], stop = hdr[P_ADR_WIDTH-1:0]. n_samp = ((stop - start) mod 2^P_ADR_WIDTH) + 1, range 1..2^P_ADR_WIDTH. Use a P_ADR_WIDTH+1 counter.
- IDLE:
  - Candidates are channels with chan_en[i] && !hdr_empty[i].
  - Pick the first candidate after the last grant, searching upward cyclically.
  - On a pick: latch the channel, latch hdr_data for that channel, compute n_samp, go to HDR.
  - With no candidate, stay in IDLE.
- HDR:
  - out_valid=1, out_is_hdr=1, out_data=latched header.
  - On transfer: hdr_rdreq[ch]=1 for exactly one cycle (the following cycle), go to RD.
- RD: wvb_rdreq[ch]=1 for one cycle, go to WAIT.
- WAIT: one cycle; capture wvb_data[ch] at the end of the cycle, go to DATA.
- DATA:
  - out_valid=1, out_is_hdr=0, out_last=(sample index == n_samp-1).
  - On transfer with more samples left: index++, go to RD.
  - On transfer of the last sample: go to DONE.
  - Throughput is one sample per 3 cycles when out_ready is held high.
- DONE (1 cycle): wvb_rddone[ch]=1, wvf_count++, round-robin pointer = ch, go to IDLE.
- Strobe rules:
  - At most one bit of each strobe vector is high in any cycle.
  - Strobes are never high in IDLE.
- chan_en deasserted mid-waveform: the current waveform completes normally; the channel is excluded from the next arbitration.
- hdr_empty asserting after the header is latched: ignored.
- Reset mid-waveform: abort immediately and issue no rddone. The buffers are reset by the same reset.
- Simultaneous requests: the round-robin search guarantees each enabled, non-empty channel is served within P_N_CHAN waveforms.

Optional Feature:
- Macro WVB_RDR_TRAILER_EN.
- When defined:
  - After the last sample transfers, a TRLR state emits one extra word.
  - Trailer word: out_is_hdr=0, out_last=1, out_data = {zeros, 16'hA5A5, out_chan zero-extended to 8 bits, n_samp zero-extended to 16 bits}.
  - Sample words then all have out_last=0.
  - DONE follows the trailer transfer.
- When undefined: no TRLR state; out_last is set on the final sample.

Test Plan:
- Ch1 only, header start=0x010 stop=0x013, out_ready=1 -> header word, then 4 samples in order; out_last on the 4th; one wvb_rddone[1] pulse; wvf_count=1.
- Ch0 and ch2 both non-empty, last grant=ch0 -> ch2 served first, then ch0, then ch2; no channel granted twice while another candidate is waiting.
- Wrap-around, start=0xFFE stop=0x001 -> n_samp=4; start=stop=0x005 -> exactly 1 sample with out_last.
- Backpressure: out_ready=0 for 5 cycles during DATA -> out_data stable, no additional wvb_rdreq; read resumes one cycle after out_ready=1.
- chan_en[1] dropped mid-waveform -> waveform finishes with rddone; ch1 not re-granted while still non-empty. rst_n low mid-DATA -> all strobes and out_valid=0 asynchronously; IDLE after release.
- With WVB_RDR_TRAILER_EN, start=0 stop=2 on ch3 -> 3 samples with out_last=0, then trailer 0x...A5A5_03_0003 with out_last=1.
